mul_div_seq: RTL

- Parametrised iterative multiply/divide unit; successor to the fixed 32-bit shift-add/restoring unit.
- Sits beside the ALU in the execute stage. The pipeline drives a start pulse and stalls on busy.
- Adds the following over the previous unit:
  - Explicit start/done handshake and a real reset.
  - Full-width signed product correction (both halves).
  - Signed remainder.
  - Defined divide-by-zero behaviour.
  - Results held stable until the next start.

---
 rtl/mul_div_seq_if.sv | 27 ++
 rtl/mul_div_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq_if.sv
// Request/result bundle between the execute stage and mul_div_seq.
// master: pipeline (start/op/operands); slave: unit (high/low/busy/done/div_zero).
interface mul_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs1;
    logic             rs1_signed;
    logic [WIDTH-1:0] rs2;
    logic             rs2_signed;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] low;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, rs1, rs1_signed, rs2, rs2_signed,
        input  high, low, busy, done, div_zero
    );

    modport slave (
        input  start, op, rs1, rs1_signed, rs2, rs2_signed,
        output high, low, busy, done, div_zero
    );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Ports: clk, rst_n (async, active low), bus (slave side of mul_div_seq_if).
module mul_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic        clk,
    input logic        rst_n,
    mul_div_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_FIN
    } state_t;

    localparam int AW = 2 * WIDTH + 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_neg1;
    logic             r_neg_res;
    logic             r_dz;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_low;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic             w_legal;
    logic             w_is_div;
    logic             w_neg1;
    logic             w_neg2;
    logic             w_rs2_zero;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_acc_lo;
    logic [WIDTH:0]   w_mul_hi;
    logic [AW-1:0]    w_mul_nxt;
    logic [AW-1:0]    w_dsh;
    logic [WIDTH:0]   w_rem;
    logic             w_ge;
    logic [AW-1:0]    w_div_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_legal    = (bus.op == 2'b01) || (bus.op == 2'b10);
    assign w_is_div   = (bus.op == 2'b10);
    assign w_neg1     = bus.rs1_signed & bus.rs1[WIDTH-1];
    assign w_neg2     = bus.rs2_signed & bus.rs2[WIDTH-1];
    assign w_rs2_zero = (bus.rs2 == '0);
    assign w_abs1     = w_neg1 ? ({WIDTH{1'b0}} - bus.rs1) : bus.rs1;
    assign w_abs2     = w_neg2 ? ({WIDTH{1'b0}} - bus.rs2) : bus.rs2;

    // MUL keeps the multiplier in the low half; DIV keeps the dividend there.
    // On divide by zero the raw dividend is parked instead so it can be
    // returned unchanged as the remainder.
    assign w_acc_lo = !w_is_div  ? w_abs2  :
                      w_rs2_zero ? bus.rs1 : w_abs1;

    // Shift-add step: conditional add into the upper W+1 bits, then shift right.
    assign w_mul_hi  = r_acc[0] ? (r_acc[AW-1:WIDTH] + {1'b0, r_opnd})
                                : r_acc[AW-1:WIDTH];
    assign w_mul_nxt = {1'b0, w_mul_hi, r_acc[WIDTH-1:1]};

    // Restoring step: shift {rem, quo} left, trial subtract into rem.
    // rem stays below the divisor, so the dropped top bit is always zero.
    assign w_dsh     = {r_acc[AW-2:0], 1'b0};
    assign w_rem     = w_dsh[AW-1:WIDTH];
    assign w_ge      = (w_rem >= {1'b0, r_opnd});
    assign w_div_nxt = w_ge ? {w_rem - {1'b0, r_opnd}, w_dsh[WIDTH-1:1], 1'b1}
                            : w_dsh;

    // Sign correction spans the whole product so the high half is right too.
    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = r_neg_res ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
    assign w_quo_fix  = r_neg_res ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0])
                                  : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg1 ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH])
                               : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg1     <= 1'b0;
            r_neg_res  <= 1'b0;
            r_dz       <= 1'b0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_high     <= '0;
            r_low      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // r_done marks the completion cycle, which still
                    // belongs to the finishing operation.
                    if (bus.start && w_legal && !r_done) begin
                        r_is_div   <= w_is_div;
                        r_neg1     <= w_neg1;
                        r_neg_res  <= w_neg1 ^ w_neg2;
                        r_dz       <= w_is_div && w_rs2_zero;
                        r_opnd     <= w_is_div ? w_abs2 : w_abs1;
                        r_acc      <= {{(WIDTH+1){1'b0}}, w_acc_lo};
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_dz) begin
                        r_res_hi <= r_acc[WIDTH-1:0];
                        r_res_lo <= '1;
                        r_state  <= S_FIN;
                    end else begin
                        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_res_hi <= w_rem_fix;
                        r_res_lo <= w_quo_fix;
                    end else begin
                        r_res_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_res_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_high     <= r_res_hi;
                    r_low      <= r_res_lo;
                    r_div_zero <= r_dz;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.high     = r_high;
    assign bus.low      = r_low;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
endmodule
